// File: rtl/llc_input_scheduler_pkg.sv
// rtl/llc_input_scheduler_pkg.sv - shared constants, state type and pick helper for the LLC input scheduler
//
// Purpose: source index constants, scheduler FSM state type, default starvation
//          limit and the fixed-priority one-hot picker used by the scheduler.
// Ports:   none (package).

package llc_input_scheduler_pkg;

   // Grant bit positions; a lower index means a higher fixed priority.
   localparam int LLC_SRC_RESUME   = 0;
   localparam int LLC_SRC_RST_TB   = 1;
   localparam int LLC_SRC_RSP      = 2;
   localparam int LLC_SRC_REQ      = 3;
   localparam int LLC_SRC_DMA      = 4;
   localparam int LLC_NUM_SRC      = 5;

   localparam int LLC_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      LLC_ST_IDLE   = 2'd0,
      LLC_ST_DECODE = 2'd1,
      LLC_ST_RD_SET = 2'd2
   } llc_sched_state_t;

   // Isolates the lowest set bit, which is the highest-priority eligible source.
   function automatic logic [LLC_NUM_SRC-1:0] llc_pick_fixed(input logic [LLC_NUM_SRC-1:0] elig);
      return elig & (~elig + LLC_NUM_SRC'(1));
   endfunction

endpackage

// File: rtl/llc_starve_counter.sv
// rtl/llc_starve_counter.sv - saturating skipped-grant counter for one starvable source
//
// Purpose: counts decisions in which its source was eligible but lost; saturates
//          at LIMIT and clears when the source is granted.
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_inc       source eligible but not granted this decision
//   i_clr       source granted this decision (wins over i_inc)
//   o_at_limit  counter equals LIMIT

module llc_starve_counter #(
   parameter int LIMIT = 8,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != W'(LIMIT))) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_at_limit = (r_cnt == W'(LIMIT));

endmodule

// File: rtl/llc_input_scheduler.sv
// rtl/llc_input_scheduler.sv - LLC input decode sequencer: source arbitration, decoder strobes, channel pops
//
// Purpose: in IDLE picks one eligible source (resume > rst_tb > rsp > req > dma),
//          holds it in grant, strobes decode_en for one cycle, then rd_set_en until
//          pipe_ready, popping the granted channel in the accepting cycle.
// Build option: LLC_STARVE_GUARD_EN adds req/dma starvation counters that promote
//          a starved source above rst_tb and rsp.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rst_tb_valid, rsp_valid,
//   req_valid, dma_req_valid      channel inputs pending
//   rst_stall, flush_stall        sweep stalled, resume wanted
//   req_stall                     masks req and dma
//   recall_pending                only rsp may be chosen
//   pipe_ready                    lookup stage accepts the set read
//   grant[4:0]                    one-hot {dma, req, rsp, rst_tb, resume}
//   decode_en, rd_set_en          decoder strobes
//   rst_tb_pop, rsp_pop,
//   req_pop, dma_req_pop          channel dequeue pulses
//   busy                          FSM not idle
//   starve_promote                current grant won by starvation promotion

module llc_input_scheduler
   import llc_input_scheduler_pkg::*;
#(
   parameter int STARVE_LIMIT = LLC_STARVE_LIMIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rst_tb_valid,
   input  logic       rsp_valid,
   input  logic       req_valid,
   input  logic       dma_req_valid,
   input  logic       rst_stall,
   input  logic       flush_stall,
   input  logic       req_stall,
   input  logic       recall_pending,
   input  logic       pipe_ready,
   output logic [4:0] grant,
   output logic       decode_en,
   output logic       rd_set_en,
   output logic       rst_tb_pop,
   output logic       rsp_pop,
   output logic       req_pop,
   output logic       dma_req_pop,
   output logic       busy,
   output logic       starve_promote
);

   llc_sched_state_t       r_state;
   llc_sched_state_t       w_state_next;
   logic [LLC_NUM_SRC-1:0] w_elig;
   logic [LLC_NUM_SRC-1:0] w_fixed;
   logic [LLC_NUM_SRC-1:0] w_pick;
   logic [LLC_NUM_SRC-1:0] r_grant;
   logic                   w_promote;
   logic                   r_promote;
   logic                   w_decide;
   logic                   w_accept;
   logic                   w_decode_en;
   logic                   w_rd_set_en;

   always_comb begin
      w_elig                 = '0;
      w_elig[LLC_SRC_RESUME] = rst_stall | flush_stall;
      w_elig[LLC_SRC_RST_TB] = rst_tb_valid;
      w_elig[LLC_SRC_RSP]    = rsp_valid;
      w_elig[LLC_SRC_REQ]    = req_valid & ~req_stall;
      w_elig[LLC_SRC_DMA]    = dma_req_valid & ~req_stall;
      // An outstanding recall can only be retired by a response.
      if (recall_pending) begin
         w_elig = w_elig & (LLC_NUM_SRC'(1) << LLC_SRC_RSP);
      end
   end

   assign w_fixed  = llc_pick_fixed(w_elig);
   assign w_decide = (r_state == LLC_ST_IDLE) && (|w_elig);

`ifdef LLC_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic w_req_at_limit;
   logic w_dma_at_limit;
   logic w_promo_ok;
   logic w_promote_req;
   logic w_promote_dma;

   // Resume and recall handling are never overtaken by a starved source.
   assign w_promo_ok    = ~w_elig[LLC_SRC_RESUME] & ~recall_pending;
   assign w_promote_req = w_promo_ok & w_elig[LLC_SRC_REQ] & w_req_at_limit;
   assign w_promote_dma = w_promo_ok & w_elig[LLC_SRC_DMA] & w_dma_at_limit & ~w_promote_req;
   assign w_promote     = w_promote_req | w_promote_dma;

   always_comb begin
      w_pick = w_fixed;
      if (w_promote_req) begin
         w_pick = LLC_NUM_SRC'(1) << LLC_SRC_REQ;
      end else if (w_promote_dma) begin
         w_pick = LLC_NUM_SRC'(1) << LLC_SRC_DMA;
      end
   end

   llc_starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .W     (CNT_W)
   ) u_req_starve (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_inc      (w_decide & w_elig[LLC_SRC_REQ] & ~w_pick[LLC_SRC_REQ]),
      .i_clr      (w_decide & w_pick[LLC_SRC_REQ]),
      .o_at_limit (w_req_at_limit)
   );

   llc_starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .W     (CNT_W)
   ) u_dma_starve (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_inc      (w_decide & w_elig[LLC_SRC_DMA] & ~w_pick[LLC_SRC_DMA]),
      .i_clr      (w_decide & w_pick[LLC_SRC_DMA]),
      .o_at_limit (w_dma_at_limit)
   );
`else
   logic w_unused_limit;

   assign w_pick         = w_fixed;
   assign w_promote      = 1'b0;
   assign w_unused_limit = (STARVE_LIMIT == 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LLC_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_decode_en  = 1'b0;
      w_rd_set_en  = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         LLC_ST_IDLE: begin
            if (|w_elig) begin
               w_state_next = LLC_ST_DECODE;
            end
         end
         LLC_ST_DECODE: begin
            w_decode_en  = 1'b1;
            w_state_next = LLC_ST_RD_SET;
         end
         LLC_ST_RD_SET: begin
            w_rd_set_en = 1'b1;
            if (pipe_ready) begin
               w_accept     = 1'b1;
               w_state_next = LLC_ST_IDLE;
            end
         end
         default: begin
            w_state_next = LLC_ST_IDLE;
         end
      endcase
   end

   // Grant is captured at the decision and held, so late changes on the
   // valid or recall inputs cannot redirect a transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant   <= '0;
         r_promote <= 1'b0;
      end else if (w_decide) begin
         r_grant   <= w_pick;
         r_promote <= w_promote;
      end else if (w_accept) begin
         r_grant   <= '0;
         r_promote <= 1'b0;
      end
   end

   assign grant          = r_grant;
   assign starve_promote = r_promote;
   assign decode_en      = w_decode_en;
   assign rd_set_en      = w_rd_set_en;
   assign busy           = (r_state != LLC_ST_IDLE);
   assign rst_tb_pop     = w_accept & r_grant[LLC_SRC_RST_TB];
   assign rsp_pop        = w_accept & r_grant[LLC_SRC_RSP];
   assign req_pop        = w_accept & r_grant[LLC_SRC_REQ];
   assign dma_req_pop    = w_accept & r_grant[LLC_SRC_DMA];

endmodule

// File: tb/tb_llc_input_scheduler.sv
// tb/tb_llc_input_scheduler.sv - self-checking bench for llc_input_scheduler

module tb_llc_input_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst_tb_valid, rsp_valid, req_valid, dma_req_valid;
   logic       rst_stall, flush_stall, req_stall, recall_pending, pipe_ready;
   logic [4:0] grant;
   logic       decode_en, rd_set_en;
   logic       rst_tb_pop, rsp_pop, req_pop, dma_req_pop;
   logic       busy, starve_promote;

   int n_cmp  = 0;
   int n_fail = 0;

   llc_input_scheduler #(.STARVE_LIMIT(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .rst_tb_valid   (rst_tb_valid),
      .rsp_valid      (rsp_valid),
      .req_valid      (req_valid),
      .dma_req_valid  (dma_req_valid),
      .rst_stall      (rst_stall),
      .flush_stall    (flush_stall),
      .req_stall      (req_stall),
      .recall_pending (recall_pending),
      .pipe_ready     (pipe_ready),
      .grant          (grant),
      .decode_en      (decode_en),
      .rd_set_en      (rd_set_en),
      .rst_tb_pop     (rst_tb_pop),
      .rsp_pop        (rsp_pop),
      .req_pop        (req_pop),
      .dma_req_pop    (dma_req_pop),
      .busy           (busy),
      .starve_promote (starve_promote)
   );

   always #5 clk = ~clk;

   wire [3:0]  pops     = {dma_req_pop, req_pop, rsp_pop, rst_tb_pop};
   wire [12:0] all_outs = {grant, decode_en, rd_set_en, pops, busy, starve_promote};

   // in = {recall, req_stall, flush_stall, rst_stall, dma, req, rsp, rst_tb}
   typedef struct {
      logic [7:0] in;
      logic [4:0] exp_grant;
   } vec_t;

   vec_t vecs[12];

`ifdef LLC_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] v);
      {recall_pending, req_stall, flush_stall, rst_stall,
       dma_req_valid, req_valid, rsp_valid, rst_tb_valid} = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(8'h00);
      pipe_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Waits for the decision and the accepting cycle of one transaction.
   task automatic txn(input string nm, input logic [4:0] exp_g, input logic exp_p, input bit drop);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (decode_en) seen = 1'b1;
      end
      chk($sformatf("%s_decode_seen", nm), 32'(seen), 32'd1);
      if (seen) begin
         chk($sformatf("%s_grant", nm), 32'(grant), 32'(exp_g));
         chk($sformatf("%s_promote", nm), 32'(starve_promote), 32'(exp_p));
         seen = 1'b0;
         for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (rd_set_en && pipe_ready) seen = 1'b1;
         end
         chk($sformatf("%s_accept_seen", nm), 32'(seen), 32'd1);
         if (seen) begin
            chk($sformatf("%s_pops", nm), 32'(pops), 32'(exp_g[4:1]));
            if (drop) begin
               if (rst_tb_pop)  rst_tb_valid  = 1'b0;
               if (rsp_pop)     rsp_valid     = 1'b0;
               if (req_pop)     req_valid     = 1'b0;
               if (dma_req_pop) dma_req_valid = 1'b0;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{8'b0000_0010, 5'b00100};
      vecs[1]  = '{8'b0000_0100, 5'b01000};
      vecs[2]  = '{8'b0000_1000, 5'b10000};
      vecs[3]  = '{8'b0000_0001, 5'b00010};
      vecs[4]  = '{8'b0001_1111, 5'b00001};
      vecs[5]  = '{8'b0010_0010, 5'b00001};
      vecs[6]  = '{8'b0000_1100, 5'b01000};
      vecs[7]  = '{8'b0100_1110, 5'b00100};
      vecs[8]  = '{8'b0100_1100, 5'b00000};
      vecs[9]  = '{8'b1001_1101, 5'b00000};
      vecs[10] = '{8'b1000_0011, 5'b00100};
      vecs[11] = '{8'b0000_0011, 5'b00010};

      // Reset state
      set_in(8'h00);
      pipe_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      chk("reset_outs", 32'(all_outs), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_outs", 32'(all_outs), 32'd0);

      // Single-decision vectors with exact cycle timing
      for (int i = 0; i < 12; i++) begin
         do_reset();
         set_in(vecs[i].in);
         step();
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         chk($sformatf("vec%0d_decode", i), 32'(decode_en), 32'(vecs[i].exp_grant != 0));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_grant != 0));
         if (vecs[i].exp_grant != 0) begin
            step();
            chk($sformatf("vec%0d_rd_set", i), 32'(rd_set_en), 32'd1);
            chk($sformatf("vec%0d_pops", i), 32'(pops), 32'({vecs[i].exp_grant[4:1]}));
            set_in(8'h00);
            step();
            chk($sformatf("vec%0d_done", i), 32'({busy, grant, pops}), 32'd0);
         end
         set_in(8'h00);
      end

      // Three sources pending: served in priority order, each popped once
      do_reset();
      set_in(8'b0000_0111);
      txn("order1", 5'b00010, 1'b0, 1'b1);
      txn("order2", 5'b00100, 1'b0, 1'b1);
      txn("order3", 5'b01000, GUARD, 1'b1);
      chk("order_valids_left", 32'({rst_tb_valid, rsp_valid, req_valid}), 32'd0);

      // Recall blocks everything but rsp
      do_reset();
      set_in(8'b1000_1100);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("recall_idle%0d", i), 32'({busy, grant}), 32'd0);
      end
      rsp_valid = 1'b1;
      txn("recall_rsp", 5'b00100, 1'b0, 1'b1);
      set_in(8'h00);

      // Stalled set read: rd_set_en held, single pop on acceptance
      do_reset();
      pipe_ready = 1'b0;
      rsp_valid  = 1'b1;
      step();
      chk("stall_decode", 32'(decode_en), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall_rd_set%0d", i), 32'({rd_set_en, pops}), 32'b1_0000);
      end
      pipe_ready = 1'b1;
      #1;
      chk("stall_pop", 32'({rd_set_en, pops}), 32'b1_0010);
      rsp_valid = 1'b0;
      step();
      chk("stall_after", 32'({busy, pops, grant}), 32'd0);

      // Continuous rsp + req: starvation promotion only with the guard
      do_reset();
      rsp_valid = 1'b1;
      req_valid = 1'b1;
      txn("starve1", 5'b00100, 1'b0, 1'b0);
      txn("starve2", 5'b00100, 1'b0, 1'b0);
      txn("starve3", GUARD ? 5'b01000 : 5'b00100, GUARD, 1'b0);
      txn("starve4", 5'b00100, 1'b0, 1'b0);
      set_in(8'h00);

      // Reset during RD_SET aborts without a pop, then source is re-granted
      do_reset();
      pipe_ready = 1'b0;
      rsp_valid  = 1'b1;
      step();
      step();
      chk("abort_in_rd_set", 32'(rd_set_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_async_outs", 32'(all_outs), 32'd0);
      step();
      chk("abort_edge_outs", 32'(all_outs), 32'd0);
      rst = 1'b0;
      pipe_ready = 1'b1;
      txn("abort_regrant", 5'b00100, 1'b0, 1'b1);
      set_in(8'h00);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
